// File: rtl/simple_circuit_pipe.sv
// Pipelined d = (a & b) | ~c, e = ~c over WIDTH-bit vectors with valid/ready on both sides.
// Stages compact into empty slots; xfer_count counts output transfers and wraps.
module simple_circuit_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [CNT_W-1:0] xfer_count
);

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  d_d [STAGES];
    logic [WIDTH-1:0]  e_q [STAGES];
    logic [WIDTH-1:0]  e_d [STAGES];
    logic [STAGES-1:0] stage_open;
    logic [CNT_W-1:0]  xfer_count_q;
    logic [CNT_W-1:0]  xfer_count_d;
    logic              accept;
    logic              xfer;

    always_comb begin
        valid_d      = valid_q;
        d_d          = d_q;
        e_d          = e_q;
        stage_open   = '0;
        accept       = 1'b0;
        xfer         = valid_q[STAGES-1] && out_ready;
        xfer_count_d = xfer_count_q;

        // Openness ripples from the output back toward the input so a full
        // pipe can still accept while the head is being consumed.
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (k == STAGES - 1) begin
                stage_open[k] = !valid_q[k] || out_ready;
            end else begin
                stage_open[k] = !valid_q[k] || stage_open[k+1];
            end
        end

        accept = in_valid && !rst && stage_open[0];

        if (stage_open[0]) begin
            valid_d[0] = accept;
            if (accept) begin
                d_d[0] = (a & b) | ~c;
                e_d[0] = ~c;
            end
        end

        for (int k = 1; k < STAGES; k++) begin
            if (stage_open[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    d_d[k] = d_q[k-1];
                    e_d[k] = e_q[k-1];
                end
            end
        end

        if (xfer) begin
            xfer_count_d = xfer_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            xfer_count_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= '0;
                e_q[k] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            xfer_count_q <= xfer_count_d;
            for (int k = 0; k < STAGES; k++) begin
                d_q[k] <= d_d[k];
                e_q[k] <= e_d[k];
            end
        end
    end

    assign in_ready   = !rst && stage_open[0];
    assign out_valid  = valid_q[STAGES-1];
    assign d          = d_q[STAGES-1];
    assign e          = e_q[STAGES-1];
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_simple_circuit_pipe.sv
// Bench for simple_circuit_pipe: a timed FIFO reference model predicts every
// handshake, result and count; each scenario task compares inline.
module tb_simple_circuit_pipe;

    localparam int W  = 4;
    localparam int S  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a, b, c;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  d, e;
    logic [CW-1:0] xfer_count;

    simple_circuit_pipe #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .e(e), .xfer_count(xfer_count)
    );

    always #5 clk = ~clk;

    // Model: a FIFO of results, each tagged with the first edge count after
    // which it may be presented at the output.
    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] e;
        int           avail;
    } ent_t;

    ent_t          mq[$];
    int            cyc;
    logic [CW-1:0] m_count;
    int            n_cmp;
    int            n_fail;

    function automatic bit m_out_valid();
        return (mq.size() > 0) && (mq[0].avail <= cyc);
    endfunction

    function automatic bit m_in_ready();
        return !rst && ((mq.size() < S) || out_ready);
    endfunction

    // One clock edge: advance the model with the pre-edge handshake values.
    task automatic cycle();
        bit   acc, xf, r;
        ent_t ent;
        acc = in_valid && m_in_ready();
        xf  = m_out_valid() && out_ready;
        r   = rst;
        ent.d = (a & b) | ~c;
        ent.e = ~c;
        @(posedge clk);
        cyc++;
        if (r) begin
            mq.delete();
            m_count = '0;
        end else begin
            if (xf) begin
                void'(mq.pop_front());
                m_count++;
                if (mq.size() > 0 && mq[0].avail < cyc) mq[0].avail = cyc;
            end
            if (acc) begin
                ent.avail = cyc + S - 1;
                mq.push_back(ent);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        a = W'($urandom); b = W'($urandom); c = W'($urandom);
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
            n_cmp++; if (d !== '0 || e !== '0) begin n_fail++; $display("FAIL reset_de: got d=%b e=%b want 0/0", d, e); end
            n_cmp++; if (xfer_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", xfer_count); end
        end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_legacy();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic [W-1:0] tc [4];
        logic [W-1:0] td [4];
        logic [W-1:0] te [4];
        int acc_cyc [4];
        int k;
        ta[0] = 4'b1111; tb[0] = 4'b0000; tc[0] = 4'b0000; td[0] = 4'b1111; te[0] = 4'b1111;
        ta[1] = 4'b0000; tb[1] = 4'b1111; tc[1] = 4'b1111; td[1] = 4'b0000; te[1] = 4'b0000;
        ta[2] = 4'b1111; tb[2] = 4'b1111; tc[2] = 4'b0000; td[2] = 4'b1111; te[2] = 4'b1111;
        ta[3] = 4'b1010; tb[3] = 4'b1100; tc[3] = 4'b0110; td[3] = 4'b1001; te[3] = 4'b1001;
        k = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 4);
            if (i < 4) begin a = ta[i]; b = tb[i]; c = tc[i]; end
            #1;
            if (i < 4) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL legacy_in_ready[%0d]: got %b want 1", i, in_ready); end
                acc_cyc[i] = cyc + 1;
            end
            cycle();
            n_cmp++; if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL legacy_out_valid@%0d: got %b want %b", i, out_valid, m_out_valid()); end
            if (out_valid && k < 4) begin
                n_cmp++; if (d !== td[k] || e !== te[k]) begin n_fail++; $display("FAIL legacy_result[%0d]: got d=%b e=%b want d=%b e=%b", k, d, e, td[k], te[k]); end
                n_cmp++; if (cyc !== acc_cyc[k] + S - 1) begin n_fail++; $display("FAIL legacy_latency[%0d]: got edge %0d want %0d", k, cyc, acc_cyc[k] + S - 1); end
                k++;
            end
        end
        n_cmp++; if (k !== 4) begin n_fail++; $display("FAIL legacy_result_count: got %0d want 4", k); end
    endtask

    task automatic test_back_to_back();
        int run, best;
        rst = 1'b1; in_valid = 1'b0; cycle(); rst = 1'b0;
        out_ready = 1'b1; run = 0; best = 0;
        for (int i = 0; i < 14; i++) begin
            in_valid = (i < 10);
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            #1;
            n_cmp++; if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL stream_in_ready@%0d: got %b want %b", i, in_ready, m_in_ready()); end
            n_cmp++; if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL stream_out_valid@%0d: got %b want %b", i, out_valid, m_out_valid()); end
            if (m_out_valid()) begin
                n_cmp++; if (d !== mq[0].d || e !== mq[0].e) begin n_fail++; $display("FAIL stream_result@%0d: got d=%b e=%b want d=%b e=%b", i, d, e, mq[0].d, mq[0].e); end
            end
            run = out_valid ? run + 1 : 0;
            if (run > best) best = run;
            cycle();
        end
        n_cmp++; if (best !== 10) begin n_fail++; $display("FAIL stream_consecutive: got %0d want 10", best); end
        n_cmp++; if (xfer_count !== 4'd10) begin n_fail++; $display("FAIL stream_count: got %0d want 10", xfer_count); end
    endtask

    task automatic test_backpressure();
        int           accepts;
        bit           have;
        logic [W-1:0] held_d, held_e;
        accepts = 0; have = 1'b0; held_d = '0; held_e = '0;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            #1;
            n_cmp++; if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL bp_in_ready@%0d: got %b want %b", i, in_ready, m_in_ready()); end
            if (in_ready) accepts++;
            if (out_valid) begin
                if (have) begin
                    n_cmp++; if (d !== held_d || e !== held_e) begin n_fail++; $display("FAIL bp_stable@%0d: got d=%b e=%b want d=%b e=%b", i, d, e, held_d, held_e); end
                end else begin
                    held_d = d; held_e = e; have = 1'b1;
                    n_cmp++; if (mq.size() == 0 || d !== mq[0].d || e !== mq[0].e) begin n_fail++; $display("FAIL bp_head: got d=%b e=%b", d, e); end
                end
            end
            cycle();
        end
        n_cmp++; if (accepts !== 2) begin n_fail++; $display("FAIL bp_accepts: got %0d want 2", accepts); end
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b1;
            in_valid  = (i < 4);
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            #1;
            n_cmp++; if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL bp_drain_in_ready@%0d: got %b want %b", i, in_ready, m_in_ready()); end
            n_cmp++; if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL bp_drain_out_valid@%0d: got %b want %b", i, out_valid, m_out_valid()); end
            if (m_out_valid()) begin
                n_cmp++; if (d !== mq[0].d || e !== mq[0].e) begin n_fail++; $display("FAIL bp_drain_result@%0d: got d=%b e=%b want d=%b e=%b", i, d, e, mq[0].d, mq[0].e); end
            end
            cycle();
        end
        n_cmp++; if (xfer_count !== m_count) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", xfer_count, m_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            #1;
            n_cmp++; if (in_ready !== m_in_ready()) begin n_fail++; $display("FAIL rand_in_ready@%0d: got %b want %b", i, in_ready, m_in_ready()); end
            n_cmp++; if (out_valid !== m_out_valid()) begin n_fail++; $display("FAIL rand_out_valid@%0d: got %b want %b", i, out_valid, m_out_valid()); end
            if (m_out_valid()) begin
                n_cmp++; if (d !== mq[0].d || e !== mq[0].e) begin n_fail++; $display("FAIL rand_result@%0d: got d=%b e=%b want d=%b e=%b", i, d, e, mq[0].d, mq[0].e); end
            end
            n_cmp++; if (xfer_count !== m_count) begin n_fail++; $display("FAIL rand_count@%0d: got %0d want %0d", i, xfer_count, m_count); end
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (S + 2) cycle();
        n_cmp++; if (out_valid !== 1'b0 || mq.size() != 0) begin n_fail++; $display("FAIL rand_drain: got out_valid=%b model_left=%0d want 0/0", out_valid, mq.size()); end
    endtask

    task automatic test_wrap();
        rst = 1'b1; in_valid = 1'b0; cycle(); rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 17 + S + 1; i++) begin
            in_valid = (i < 17);
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            cycle();
        end
        n_cmp++; if (xfer_count !== 4'd1) begin n_fail++; $display("FAIL wrap_count: got %0d want 1", xfer_count); end
        n_cmp++; if (xfer_count !== m_count) begin n_fail++; $display("FAIL wrap_model_count: got %0d want %0d", xfer_count, m_count); end
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a = W'($urandom); b = W'($urandom); c = W'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_loaded: got out_valid=%b want 1", out_valid); end
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (xfer_count !== '0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", xfer_count); end
        for (int i = 0; i < 5; i++) begin
            cycle();
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_ghost@%0d: got out_valid=%b d=%b want 0", i, out_valid, d); end
        end
        n_cmp++; if (xfer_count !== '0) begin n_fail++; $display("FAIL midrst_count_after: got %0d want 0", xfer_count); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0;
        cyc = 0; m_count = '0; n_cmp = 0; n_fail = 0;
        test_reset();
        test_legacy();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_wrap();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
